// File: rtl/sm_decoder_defs.sv
// Shared definitions for the two's-complement to sign-magnitude decoder.
// State encodings and default operand/digit widths live here only.
package sm_decoder_defs;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sm_decoder_32_inv_digit_4.sv
// One 4-bit slice of the invert-plus-one negation chain; purely combinational.
// The carry only ripples through a digit that is all zeros, so its NOR doubles as the zero detect.
module inv_digit_4 (
    input  logic [3:0] x,
    input  logic       cin,
    output logic [3:0] y,
    output logic       cout
);

    logic x_zero;

    assign x_zero = ~|x;
    assign y      = ~x + {3'b000, cin};
    assign cout   = cin & x_zero;

endmodule

// File: rtl/sm_decoder_32.sv
// Serial two's-complement to sign-magnitude converter, one DIGIT per cycle, fixed WIDTH/DIGIT cycle latency.
// Single-operand valid/ready handshake: in_ready only in IDLE, result held in DONE until out_ready.
module sm_decoder_32
    import sm_decoder_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int NSUB  = DIGIT / 4;
    localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] digit_in;
    logic [DIGIT-1:0] digit_neg;
    logic [DIGIT-1:0] digit_out;
    logic [NSUB:0]    chain;
    logic             carry_nxt;
    logic [WIDTH-1:0] shreg_nxt;

    // Negation is a ripple of 4-bit slices; the chain output seeds the next cycle's digit.
    assign digit_in = shreg[DIGIT-1:0];
    assign chain[0] = carry;

    for (genvar g = 0; g < NSUB; g++) begin : g_inv
        inv_digit_4 u_inv (
            .x    (digit_in[4*g +: 4]),
            .cin  (chain[g]),
            .y    (digit_neg[4*g +: 4]),
            .cout (chain[g+1])
        );
    end

    assign digit_out  = out_sign ? digit_neg : digit_in;
    assign carry_nxt  = out_sign ? chain[NSUB] : carry;
    assign shreg_nxt  = {digit_out, shreg[WIDTH-1:DIGIT]};
    assign last_digit = (cnt == CW'(NDIG - 1));

    assign in_ready  = (state == IDLE) && !sys_rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = CONV;
            CONV:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sign <= 1'b0;
            out_mag  <= '0;
            out_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= in_data;
                        out_sign <= in_data[WIDTH-1];
                        carry    <= 1'b1;
                        cnt      <= '0;
                    end
                end
                CONV: begin
                    shreg <= shreg_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    // Result registers only move on the final digit, so nothing partial is ever exposed.
                    if (last_digit) begin
                        out_mag  <= shreg_nxt;
                        out_zero <= (shreg_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
